// File: rtl/regs_pkg.sv
// Shared constants and types for the general-purpose register file.
//   REG_NUM     number of architectural registers (x0..x31)
//   REG_ADDR_W  register address width, log2(REG_NUM)
//   DATA_W      register width
//   reg_addr_t  register address type
//   reg_data_t  register data type
// The enable constants name the polarity of the write and read enables
// used by the execute and decode stages.
package regs_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = $clog2(REG_NUM);
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  localparam reg_data_t ZERO_WORD = '0;
  localparam reg_addr_t ZERO_ADDR = '0;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

endpackage

// File: rtl/regs_rport.sv
// One combinational read port of the register file, including the
// same-cycle write-to-read bypass.
// Ports:
//   rst          synchronous reset of the file; forces ZERO_WORD
//   re           read enable; ZERO_WORD when disabled
//   raddr        register address being read
//   we/waddr/wdata  write-back triple presented this cycle (bypass source)
//   array_rdata  storage value for raddr (ZERO_WORD for x0)
//   rdata        read data
module regs_rport
  import regs_pkg::*;
(
  input  logic      rst,
  input  logic      re,
  input  reg_addr_t raddr,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_data_t wdata,
  input  reg_data_t array_rdata,
  output reg_data_t rdata
);

  // Priority: reset, disabled port, x0, write-first bypass, storage.
  // x0 is checked before the bypass so a write aimed at x0 never leaks
  // through to a reader of x0.
  always_comb begin
    rdata = ZERO_WORD;
    if (rst) begin
      rdata = ZERO_WORD;
    end else if (re == READ_DISABLE) begin
      rdata = ZERO_WORD;
    end else if (raddr == ZERO_ADDR) begin
      rdata = ZERO_WORD;
    end else if ((we == WRITE_ENABLE) && (waddr == raddr)) begin
      rdata = wdata;
    end else begin
      rdata = array_rdata;
    end
  end

endmodule

// File: rtl/regs.sv
// General-purpose register file for the RV32I core: one write port from
// execute, two combinational read ports for decode (with write-first
// bypass) and a debug read port that sees storage only.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   we_i, waddr_i, wdata_i   write-back triple, committed at the rising edge
//   raddr1_i, re1_i, rdata1_o  read port 1
//   raddr2_i, re2_i, rdata2_o  read port 2
//   dbg_raddr_i, dbg_rdata_o   debug read port (no enable, no bypass)
// Interface timing: there is no handshake. A write presented with we_i=1
// and rst=0 always commits at the next rising edge; reads are 0-cycle.
module regs
  import regs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic                  re1_i,
  output logic [DATA_W-1:0]     rdata1_o,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  input  logic                  re2_i,
  output logic [DATA_W-1:0]     rdata2_o,
  input  logic [REG_ADDR_W-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0]     dbg_rdata_o
);

  // x0 has no storage; entries 1..REG_NUM-1 only.
  reg_data_t mem [1:REG_NUM-1];

  reg_data_t arr_rdata1;
  reg_data_t arr_rdata2;
  reg_data_t arr_rdata_dbg;

  // Storage read that returns ZERO_WORD for x0 without touching a
  // nonexistent entry.
  function automatic reg_data_t read_entry(input reg_addr_t addr);
    reg_data_t val;
    val = ZERO_WORD;
    for (int i = 1; i < REG_NUM; i++) begin
      if (addr == i[REG_ADDR_W-1:0]) val = mem[i];
    end
    return val;
  endfunction

  // Reset clears every entry in one cycle and drops any concurrent write.
  always_ff @(posedge clk) begin
    for (int i = 1; i < REG_NUM; i++) begin
      if (rst) begin
        mem[i] <= ZERO_WORD;
      end else if ((we_i == WRITE_ENABLE) && (waddr_i == i[REG_ADDR_W-1:0])) begin
        mem[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    arr_rdata1    = read_entry(raddr1_i);
    arr_rdata2    = read_entry(raddr2_i);
    arr_rdata_dbg = read_entry(dbg_raddr_i);
  end

  regs_rport u_rport1 (
    .rst         (rst),
    .re          (re1_i),
    .raddr       (raddr1_i),
    .we          (we_i),
    .waddr       (waddr_i),
    .wdata       (wdata_i),
    .array_rdata (arr_rdata1),
    .rdata       (rdata1_o)
  );

  regs_rport u_rport2 (
    .rst         (rst),
    .re          (re2_i),
    .raddr       (raddr2_i),
    .we          (we_i),
    .waddr       (waddr_i),
    .wdata       (wdata_i),
    .array_rdata (arr_rdata2),
    .rdata       (rdata2_o)
  );

  // Debug port shows committed storage only, so it lags the bypassed ports
  // by one cycle during a write to the same register.
  always_comb begin
    dbg_rdata_o = rst ? ZERO_WORD : arr_rdata_dbg;
  end

endmodule

// File: tb/tb_regs.sv
module tb_regs;
  import regs_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr1_i;
  logic        re1_i;
  logic [31:0] rdata1_o;
  logic [4:0]  raddr2_i;
  logic        re2_i;
  logic [31:0] rdata2_o;
  logic [4:0]  dbg_raddr_i;
  logic [31:0] dbg_rdata_o;

  always #5 clk = ~clk;

  regs dut (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .raddr1_i    (raddr1_i),
    .re1_i       (re1_i),
    .rdata1_o    (rdata1_o),
    .raddr2_i    (raddr2_i),
    .re2_i       (re2_i),
    .rdata2_o    (rdata2_o),
    .dbg_raddr_i (dbg_raddr_i),
    .dbg_rdata_o (dbg_rdata_o)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic we, input logic [4:0] a, input logic [31:0] d);
    we_i = we; waddr_i = a; wdata_i = d;
  endtask

  task automatic drive_read(input logic [4:0] a1, input logic e1,
                            input logic [4:0] a2, input logic e2,
                            input logic [4:0] ad);
    raddr1_i = a1; re1_i = e1; raddr2_i = a2; re2_i = e2; dbg_raddr_i = ad;
  endtask

  // Advance one edge, updating the reference model from the held inputs,
  // then leave inputs settled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we_i && waddr_i != 5'd0) begin
      model[waddr_i] = wdata_i;
    end
    #1;
  endtask

  // Reference expectations from the specification.
  function automatic logic [31:0] exp_port(input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return 32'h0;
    if (we_i && waddr_i == a) return wdata_i;
    return model[a];
  endfunction

  function automatic logic [31:0] exp_dbg(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    return model[a];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] obs [3];
    logic [31:0] exp;
    // During reset, with a write to x5 pending, every output reads zero.
    rst = 1'b1;
    drive_write(1'b1, 5'd5, 32'hDEADBEEF);
    drive_read(5'd5, 1'b1, 5'd5, 1'b1, 5'd5);
    #2;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    obs = '{rdata1_o, rdata2_o, dbg_rdata_o};
    for (int k = 0; k < 3; k++) begin
      checks++;
      exp = exp_q.pop_front();
      if (obs[k] !== exp) begin
        errors++;
        $display("FAIL reset_hold port%0d got %h exp %h", k, obs[k], exp);
      end
    end
    tick();
    // Write DEADBEEF to x5, then reset for one cycle with a write pending.
    rst = 1'b0;
    tick();
    drive_write(1'b0, 5'd0, 32'h0);
    #2;
    checks++;
    if (dbg_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_prewrite got %h exp %h", dbg_rdata_o, 32'hDEADBEEF);
    end
    rst = 1'b1;
    drive_write(1'b1, 5'd5, 32'h0BADF00D);
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    obs = '{rdata1_o, rdata2_o, dbg_rdata_o};
    for (int k = 0; k < 3; k++) begin
      checks++;
      exp = exp_q.pop_front();
      if (obs[k] !== exp) begin
        errors++;
        $display("FAIL reset_during port%0d got %h exp %h", k, obs[k], exp);
      end
    end
    tick();
    rst = 1'b0;
    drive_write(1'b0, 5'd0, 32'h0);
    #2;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    obs = '{rdata1_o, rdata2_o, dbg_rdata_o};
    for (int k = 0; k < 3; k++) begin
      checks++;
      exp = exp_q.pop_front();
      if (obs[k] !== exp) begin
        errors++;
        $display("FAIL reset_cleared port%0d got %h exp %h", k, obs[k], exp);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] obs [3];
    logic [31:0] exp;
    drive_write(1'b1, 5'd10, 32'h12345678);
    drive_read(5'd1, 1'b1, 5'd2, 1'b1, 5'd1);
    tick();
    drive_write(1'b0, 5'd0, 32'h0);
    drive_read(5'd10, 1'b1, 5'd10, 1'b1, 5'd10);
    #2;
    exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
    obs = '{rdata1_o, rdata2_o, dbg_rdata_o};
    for (int k = 0; k < 3; k++) begin
      checks++;
      exp = exp_q.pop_front();
      if (obs[k] !== exp) begin
        errors++;
        $display("FAIL write_read port%0d got %h exp %h", k, obs[k], exp);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] obs [3];
    logic [31:0] exp;
    drive_write(1'b1, 5'd3, 32'h11111111);
    tick();
    // Same-cycle write: both ports bypass, debug still shows storage.
    drive_write(1'b1, 5'd3, 32'h22222222);
    drive_read(5'd3, 1'b1, 5'd3, 1'b1, 5'd3);
    #2;
    exp_q.push_back(32'h22222222); exp_q.push_back(32'h22222222); exp_q.push_back(32'h11111111);
    obs = '{rdata1_o, rdata2_o, dbg_rdata_o};
    for (int k = 0; k < 3; k++) begin
      checks++;
      exp = exp_q.pop_front();
      if (obs[k] !== exp) begin
        errors++;
        $display("FAIL bypass_same port%0d got %h exp %h", k, obs[k], exp);
      end
    end
    tick();
    drive_write(1'b0, 5'd0, 32'h0);
    #2;
    exp_q.push_back(32'h22222222); exp_q.push_back(32'h22222222); exp_q.push_back(32'h22222222);
    obs = '{rdata1_o, rdata2_o, dbg_rdata_o};
    for (int k = 0; k < 3; k++) begin
      checks++;
      exp = exp_q.pop_front();
      if (obs[k] !== exp) begin
        errors++;
        $display("FAIL bypass_next port%0d got %h exp %h", k, obs[k], exp);
      end
    end
  endtask

  task automatic test_x0();
    logic [31:0] obs [3];
    logic [31:0] exp;
    drive_write(1'b1, 5'd0, 32'hFFFFFFFF);
    drive_read(5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    for (int c = 0; c < 3; c++) begin
      #2;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      obs = '{rdata1_o, rdata2_o, dbg_rdata_o};
      for (int k = 0; k < 3; k++) begin
        checks++;
        exp = exp_q.pop_front();
        if (obs[k] !== exp) begin
          errors++;
          $display("FAIL x0 cycle%0d port%0d got %h exp %h", c, k, obs[k], exp);
        end
      end
      tick();
    end
    drive_write(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_re_gating();
    logic [31:0] exp;
    drive_write(1'b1, 5'd7, 32'hA5A5A5A5);
    tick();
    drive_write(1'b0, 5'd0, 32'h0);
    drive_read(5'd7, 1'b0, 5'd7, 1'b0, 5'd7);
    #2;
    exp_q.push_back(32'h0);
    checks++;
    exp = exp_q.pop_front();
    if (rdata2_o !== exp) begin
      errors++;
      $display("FAIL re_off got %h exp %h", rdata2_o, exp);
    end
    re2_i = 1'b1;
    #1;
    exp_q.push_back(32'hA5A5A5A5);
    checks++;
    exp = exp_q.pop_front();
    if (rdata2_o !== exp) begin
      errors++;
      $display("FAIL re_on got %h exp %h", rdata2_o, exp);
    end
    // Disabled port also masks a bypass hit.
    drive_write(1'b1, 5'd7, 32'h5A5A5A5A);
    #1;
    exp_q.push_back(32'h0);
    checks++;
    exp = exp_q.pop_front();
    if (rdata1_o !== exp) begin
      errors++;
      $display("FAIL re_off_bypass got %h exp %h", rdata1_o, exp);
    end
    tick();
    drive_write(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_sweep();
    logic [31:0] obs [3];
    logic [31:0] exp;
    logic [31:0] v;
    for (int a = 1; a < 32; a++) begin
      v = (32'(a) << 24) | 32'(a);
      drive_write(1'b1, 5'(a), v);
      tick();
    end
    drive_write(1'b0, 5'd0, 32'h0);
    for (int a = 0; a < 32; a++) begin
      v = (a == 0) ? 32'h0 : ((32'(a) << 24) | 32'(a));
      drive_read(5'(a), 1'b1, 5'(a), 1'b1, 5'(a));
      #1;
      exp_q.push_back(v); exp_q.push_back(v); exp_q.push_back(v);
      obs = '{rdata1_o, rdata2_o, dbg_rdata_o};
      for (int k = 0; k < 3; k++) begin
        checks++;
        exp = exp_q.pop_front();
        if (obs[k] !== exp) begin
          errors++;
          $display("FAIL sweep x%0d port%0d got %h exp %h", a, k, obs[k], exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] obs [3];
    logic [31:0] exp;
    for (int c = 0; c < 200; c++) begin
      drive_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      drive_read(5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)));
      rst = ($urandom_range(0, 49) == 0);
      #2;
      exp_q.push_back(exp_port(re1_i, raddr1_i));
      exp_q.push_back(exp_port(re2_i, raddr2_i));
      exp_q.push_back(exp_dbg(dbg_raddr_i));
      obs = '{rdata1_o, rdata2_o, dbg_rdata_o};
      for (int k = 0; k < 3; k++) begin
        checks++;
        exp = exp_q.pop_front();
        if (obs[k] !== exp) begin
          errors++;
          $display("FAIL random c%0d port%0d got %h exp %h", c, k, obs[k], exp);
        end
      end
      tick();
    end
    rst = 1'b0;
    drive_write(1'b0, 5'd0, 32'h0);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1;
    drive_write(1'b0, 5'd0, 32'h0);
    drive_read(5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_re_gating();
    test_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
